dmem_port_arbiter: RTL and testbench

- Shares the single data-memory port between two masters: m0 (core memory stage) and m1 (DMA/TDMA master).
- Sits between those masters and the data memory/cache port.
- One transaction in flight at a time. Round-robin arbitration between masters.
- A timeout watchdog keeps a hung memory response from deadlocking either master.

---
 rtl/dmem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_port_arbiter
//   Round-robin sharing of one data-memory port between two masters, with one
//   transaction in flight and a response-timeout watchdog.
//   Revision: 1.0
// ============================================================================
module dmem_port_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH/8-1:0] m0_byte_en,
  input  logic [ADDRESS_BITS-1:0] m0_address_out,
  input  logic [DATA_WIDTH-1:0]   m0_data_out,
  output logic [DATA_WIDTH-1:0]   m0_data_in,
  output logic                    m0_valid,
  output logic                    m0_ready,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH/8-1:0] m1_byte_en,
  input  logic [ADDRESS_BITS-1:0] m1_address_out,
  input  logic [DATA_WIDTH-1:0]   m1_data_out,
  output logic [DATA_WIDTH-1:0]   m1_data_in,
  output logic                    m1_valid,
  output logic                    m1_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  output logic [ADDRESS_BITS-1:0] mem_address_in,
  output logic [DATA_WIDTH-1:0]   mem_data_in,
  input  logic [DATA_WIDTH-1:0]   mem_data_out,
  input  logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    timeout_err
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;   // 1 = m1 was served last
  logic                    winner_q, winner_d;           // 1 = m1 owns the port
  logic                    mem_read_q, mem_read_d;
  logic                    mem_write_q, mem_write_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_WIDTH-1:0]   m1_rdata_q, m1_rdata_d;
  logic                    m0_valid_q, m0_valid_d;
  logic                    m1_valid_q, m1_valid_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic req0, req1, grant1, arb_ready;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  // On a tie the master that was not served last wins.
  assign grant1    = req1 & (~req0 | ~last_grant_q);
  assign arb_ready = (state_q == S_IDLE) & mem_ready;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    winner_d      = winner_q;
    addr_d        = addr_q;
    be_d          = be_q;
    wdata_d       = wdata_q;
    m0_rdata_d    = m0_rdata_q;
    m1_rdata_d    = m1_rdata_q;
    cnt_d         = cnt_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    m0_valid_d    = 1'b0;
    m1_valid_d    = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_ready && (req0 || req1)) begin
          winner_d = grant1;
          if (grant1) begin
            addr_d      = m1_address_out;
            be_d        = m1_byte_en;
            wdata_d     = m1_data_out;
            mem_write_d = m1_write;
            mem_read_d  = ~m1_write;
          end else begin
            addr_d      = m0_address_out;
            be_d        = m0_byte_en;
            wdata_d     = m0_data_out;
            mem_write_d = m0_write;
            mem_read_d  = ~m0_write;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid) begin
          if (winner_q) m1_rdata_d = mem_data_out;
          else          m0_rdata_d = mem_data_out;
          m0_valid_d = ~winner_q;
          m1_valid_d = winner_q;
          state_d    = S_RESP;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          if (winner_q) m1_rdata_d = '0;
          else          m0_rdata_d = '0;
          m0_valid_d    = ~winner_q;
          m1_valid_d    = winner_q;
          timeout_err_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        last_grant_d = winner_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      winner_q      <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
      m0_valid_q    <= 1'b0;
      m1_valid_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      winner_q      <= winner_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      addr_q        <= addr_d;
      be_q          <= be_d;
      wdata_q       <= wdata_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
      m0_valid_q    <= m0_valid_d;
      m1_valid_q    <= m1_valid_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign m0_ready       = arb_ready;
  assign m1_ready       = arb_ready;
  assign m0_data_in     = m0_rdata_q;
  assign m1_data_in     = m1_rdata_q;
  assign m0_valid       = m0_valid_q;
  assign m1_valid       = m1_valid_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_address_in = addr_q;
  assign mem_byte_en    = be_q;
  assign mem_data_in    = wdata_q;
  assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_dmem_port_arbiter
//   Directed scenarios plus randomized traffic against a transaction-level
//   reference model of the two-master memory port arbiter.
//   Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        m0_read = 1'b0, m0_write = 1'b0;
  logic [3:0]  m0_byte_en = '0;
  logic [31:0] m0_address_out = '0, m0_data_out = '0;
  logic [31:0] m0_data_in;
  logic        m0_valid, m0_ready;
  logic        m1_read = 1'b0, m1_write = 1'b0;
  logic [3:0]  m1_byte_en = '0;
  logic [31:0] m1_address_out = '0, m1_data_out = '0;
  logic [31:0] m1_data_in;
  logic        m1_valid, m1_ready;
  logic        mem_read, mem_write;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_address_in, mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic        mem_valid = 1'b0, mem_ready = 1'b1;
  logic        timeout_err;

  dmem_port_arbiter #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_byte_en(m0_byte_en),
    .m0_address_out(m0_address_out), .m0_data_out(m0_data_out),
    .m0_data_in(m0_data_in), .m0_valid(m0_valid), .m0_ready(m0_ready),
    .m1_read(m1_read), .m1_write(m1_write), .m1_byte_en(m1_byte_en),
    .m1_address_out(m1_address_out), .m1_data_out(m1_data_out),
    .m1_data_in(m1_data_in), .m1_valid(m1_valid), .m1_ready(m1_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_en(mem_byte_en),
    .mem_address_in(mem_address_in), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one transaction record, advanced once per clock edge.
  bit          mdl_on = 1'b0;
  bit          mdl_busy, mdl_issue, mdl_resp, mdl_to, mdl_win, mdl_last, mdl_wr;
  int          mdl_waited;
  logic [31:0] mdl_addr, mdl_wdata;
  logic [3:0]  mdl_be;
  logic [31:0] mdl_din [2];

  always @(posedge clock) begin
    bit r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (reset) begin
      mdl_on = 1'b1; mdl_busy = 1'b0; mdl_issue = 1'b0; mdl_resp = 1'b0;
      mdl_to = 1'b0; mdl_last = 1'b1; mdl_win = 1'b0; mdl_wr = 1'b0;
      mdl_addr = '0; mdl_wdata = '0; mdl_be = '0; mdl_din[0] = '0; mdl_din[1] = '0;
    end else if (mdl_resp) begin
      mdl_resp = 1'b0; mdl_to = 1'b0; mdl_busy = 1'b0; mdl_last = mdl_win;
    end else if (!mdl_busy) begin
      if (mem_ready && (r0 || r1)) begin
        mdl_win   = (r0 && r1) ? !mdl_last : r1;
        mdl_wr    = mdl_win ? m1_write : m0_write;
        mdl_addr  = mdl_win ? m1_address_out : m0_address_out;
        mdl_wdata = mdl_win ? m1_data_out : m0_data_out;
        mdl_be    = mdl_win ? m1_byte_en : m0_byte_en;
        mdl_busy  = 1'b1;
        mdl_issue = 1'b1;
      end
    end else if (mdl_issue) begin
      mdl_issue  = 1'b0;
      mdl_waited = 0;
    end else if (mem_valid) begin
      mdl_din[mdl_win] = mem_data_out;
      mdl_resp = 1'b1;
    end else if (TO != 0 && mdl_waited == TO - 1) begin
      mdl_din[mdl_win] = '0;
      mdl_to   = 1'b1;
      mdl_resp = 1'b1;
    end else begin
      mdl_waited++;
    end
  end

  always @(negedge clock) begin
    if (mdl_on) begin
      check("mem_read",       mem_read,       mdl_issue && !mdl_wr);
      check("mem_write",      mem_write,      mdl_issue && mdl_wr);
      check("mem_address_in", mem_address_in, mdl_addr);
      check("mem_data_in",    mem_data_in,    mdl_wdata);
      check("mem_byte_en",    mem_byte_en,    mdl_be);
      check("m0_valid",       m0_valid,       mdl_resp && !mdl_win);
      check("m1_valid",       m1_valid,       mdl_resp && mdl_win);
      check("timeout_err",    timeout_err,    mdl_resp && mdl_to);
      check("m0_data_in",     m0_data_in,     mdl_din[0]);
      check("m1_data_in",     m1_data_in,     mdl_din[1]);
      check("m0_ready",       m0_ready,       !mdl_busy && mem_ready);
      check("m1_ready",       m1_ready,       !mdl_busy && mem_ready);
    end
  end

  // Memory responder: answers k cycles after the strobe, or never when hung.
  bit          rand_mode = 1'b0, mem_hang = 1'b0;
  int          mem_lat = 2, mem_cd = 0;
  logic [31:0] dir_rdata = '0;

  always @(posedge clock) begin
    #1;
    mem_valid = 1'b0;
    if (reset) mem_cd = 0;
    else if (mem_read || mem_write) mem_cd = mem_hang ? 0 : mem_lat;
    else if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin
        mem_valid    = 1'b1;
        mem_data_out = rand_mode ? $urandom : dir_rdata;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drop_all();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  int          ob_who, ob_lat, ob_gap, ob_rd, ob_wr, ob_terr;
  bit          ob_stable;
  logic [31:0] ob_addr, ob_data;
  logic [3:0]  ob_be;

  // Waits for a response pulse; the responding master drops its request.
  task automatic wait_resp(input int bound, input bit perturb);
    int  strobe_at;
    bit  done;
    strobe_at = -1; done = 1'b0;
    ob_who = -1; ob_rd = 0; ob_wr = 0; ob_terr = 0; ob_stable = 1'b1; ob_gap = -1;
    for (int c = 1; c <= bound && !done; c++) begin
      tick();
      if (mem_read)  ob_rd++;
      if (mem_write) ob_wr++;
      if (mem_read || mem_write) begin
        strobe_at = c; ob_addr = mem_address_in; ob_data = mem_data_in; ob_be = mem_byte_en;
      end else if (strobe_at >= 0 &&
                   (mem_address_in !== ob_addr || mem_data_in !== ob_data || mem_byte_en !== ob_be))
        ob_stable = 1'b0;
      if (perturb && c == 3) begin
        m0_address_out = 32'hBAD0; m1_address_out = 32'hBAD4; m1_data_out = 32'hFFFF_FFFF;
      end
      if (timeout_err) ob_terr++;
      if (m0_valid || m1_valid) begin
        ob_who = m1_valid ? 1 : 0;
        ob_lat = c;
        ob_gap = (strobe_at >= 0) ? c - strobe_at : -1;
        if (m1_valid) begin m1_read = 1'b0; m1_write = 1'b0; end
        else          begin m0_read = 1'b0; m0_write = 1'b0; end
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_wait: no valid pulse within %0d cycles (t=%0t)", bound, $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd;
    tick(); tick(); tick();
    check("rst mem_read", mem_read, 0);
    check("rst mem_address_in", mem_address_in, 0);
    check("rst m0_valid", m0_valid, 0);
    check("rst m0_data_in", m0_data_in, 0);
    check("rst timeout_err", timeout_err, 0);
    check("rst m0_ready", m0_ready, 1);
    reset = 1'b0;

    // m0 read, memory answers two cycles after the strobe
    dir_rdata = 32'hDEAD_BEEF; mem_lat = 2;
    m0_address_out = 32'h100; m0_byte_en = 4'hF; m0_read = 1'b1;
    wait_resp(20, 1'b0);
    check("t1 who", ob_who, 0);
    check("t1 read pulses", ob_rd, 1);
    check("t1 addr", ob_addr, 32'h100);
    check("t1 latency", ob_lat, 4);
    check("t1 m0_data_in", m0_data_in, 32'hDEAD_BEEF);
    check("t1 m1_data_in", m1_data_in, 0);

    // both masters request continuously: alternating grants from m0
    do_reset();
    m0_address_out = 32'h1000; m1_address_out = 32'h2000;
    m0_read = 1'b1; m1_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_resp(20, 1'b0);
      check("rr grant", ob_who, i % 2);
      check("rr addr", ob_addr, (i % 2) ? 32'h2000 : 32'h1000);
      tick();
      if (i < 3) begin
        if (ob_who == 1) m1_read = 1'b1; else m0_read = 1'b1;
      end
    end
    wait_resp(20, 1'b0);

    // m1 write, request fields disturbed after capture
    do_reset();
    mem_lat = 3;
    m0_address_out = 32'h999;
    m1_address_out = 32'h40; m1_data_out = 32'h1234_5678; m1_byte_en = 4'b0011; m1_write = 1'b1;
    wait_resp(20, 1'b1);
    check("wr who", ob_who, 1);
    check("wr write pulses", ob_wr, 1);
    check("wr read pulses", ob_rd, 0);
    check("wr addr", ob_addr, 32'h40);
    check("wr data", ob_data, 32'h1234_5678);
    check("wr be", ob_be, 4'b0011);
    check("wr stable", ob_stable, 1);

    // hung memory: abort after TO wait cycles, then a normal transaction
    mem_hang = 1'b1;
    m0_address_out = 32'h200; m0_read = 1'b1;
    wait_resp(40, 1'b0);
    check("to who", ob_who, 0);
    check("to strobe-to-valid", ob_gap, TO + 1);
    check("to m0_data_in", m0_data_in, 0);
    check("to err pulses", ob_terr, 1);
    tick();
    check("to err drop", timeout_err, 0);
    mem_hang = 1'b0; mem_lat = 1; dir_rdata = 32'hA5A5_0001;
    m0_read = 1'b1;
    wait_resp(20, 1'b0);
    check("post-to data", m0_data_in, 32'hA5A5_0001);
    check("post-to err", ob_terr, 0);
    check("post-to latency", ob_lat, 3);

    // memory not ready: no grant until mem_ready rises
    mem_ready = 1'b0; m0_address_out = 32'h300; m0_read = 1'b1;
    nrd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_read) nrd++;
    end
    check("nr m0_ready", m0_ready, 0);
    check("nr no strobe", nrd, 0);
    mem_ready = 1'b1;
    tick();
    check("nr strobe next", mem_read, 1);
    wait_resp(20, 1'b0);

    // reset in the middle of WAIT
    mem_hang = 1'b1; m0_address_out = 32'h400; m0_read = 1'b1;
    tick(); tick(); tick();
    reset = 1'b1; m0_read = 1'b0;
    tick();
    check("rw mem_read", mem_read, 0);
    check("rw mem_address_in", mem_address_in, 0);
    check("rw m0_valid", m0_valid, 0);
    check("rw m0_data_in", m0_data_in, 0);
    reset = 1'b0; mem_hang = 1'b0; mem_lat = 2;
    m0_read = 1'b1; m1_read = 1'b1;
    wait_resp(20, 1'b0);
    check("rw first grant", ob_who, 0);
    wait_resp(20, 1'b0);
    check("rw second grant", ob_who, 1);

    // randomized traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        drop_all();
        continue;
      end
      mem_ready = ($urandom_range(0, 3) != 0);
      mem_lat   = $urandom_range(1, 4);
      mem_hang  = ($urandom_range(0, 9) == 0);
      if (m0_valid) begin
        m0_read = 1'b0; m0_write = 1'b0;
      end else if (!(m0_read || m0_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          logic [1:0] op;
          op = 2'($urandom_range(1, 3));
          m0_read = op[0]; m0_write = op[1];
          m0_address_out = $urandom; m0_data_out = $urandom; m0_byte_en = 4'($urandom);
        end
      end else if (mdl_busy && !mdl_win && $urandom_range(0, 3) == 0) begin
        m0_address_out = $urandom; m0_data_out = $urandom;
      end
      if (m1_valid) begin
        m1_read = 1'b0; m1_write = 1'b0;
      end else if (!(m1_read || m1_write)) begin
        if ($urandom_range(0, 2) == 0) begin
          logic [1:0] op;
          op = 2'($urandom_range(1, 3));
          m1_read = op[0]; m1_write = op[1];
          m1_address_out = $urandom; m1_data_out = $urandom; m1_byte_en = 4'($urandom);
        end
      end else if (mdl_busy && mdl_win && $urandom_range(0, 3) == 0) begin
        m1_address_out = $urandom; m1_data_out = $urandom;
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
